dnn_accel_system_keys: RTL and testbench
========================================

# dnn_accel_system_keys

Avalon-MM slave input port: the read-side counterpart of the seven-segment output PIOs. Samples an external WIDTH-bit input bus (push-buttons/switches), synchronises and debounces each bit, captures qualifying edges into sticky per-bit flags, and raises a maskable level interrupt to the processor. Sits on the system interconnect beside the hex output ports; software polls the data register or services the IRQ.

## Interface

Parameters:
- WIDTH, 4: number of input bits (1..32).
- DEBOUNCE_CYCLES, 16: consecutive clk cycles a synchronised bit must differ from its stable value before the stable value changes (≥1).
- EDGE_MODE, 1: 0 = rising, 1 = falling, 2 = any edge sets capture.
- IDLE_LEVEL, all ones: reset value of synchroniser and stable registers (buttons idle high).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  2  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, zero-extended, combinational from address.
- in_port  in  WIDTH  asynchronous external inputs.
- irq  out  1  level interrupt.

## Operation

- Register map (zero wait states, read latency 0): addr 0 = stable data (RO); addr 1 = reads 0, writes ignored; addr 2 = irq mask (RW, WIDTH bits); addr 3 = edge capture (read; write 1 to clear per bit, 0 leaves bit).
- Write qualifies when chipselect && !write_n. Bits above WIDTH read 0, ignored on write.
- Per bit: two-flop synchroniser s1→s2. Counter cnt (width clog2(DEBOUNCE_CYCLES)+1): if s2 == stable, cnt←0; else if cnt == DEBOUNCE_CYCLES−1, stable←s2, cnt←0; else cnt←cnt+1. Any glitch back to stable restarts the count.
- Edge qualifies on the cycle stable changes: rising = 0→1, falling = 1→0, any = either. Qualifying edge sets capture bit on the same clk edge as the stable update.
- irq = |(capture & mask), combinational from registers.
- Reset: s1, s2, stable ← IDLE_LEVEL; cnt ← 0; mask ← 0; capture ← 0; irq = 0; readdata = 0 unless addressed register is non-zero (data reads IDLE_LEVEL).

## Timing

- in_port change settling before edge E1: s1 at E1, s2 at E2, stable and capture update at edge E(2+DEBOUNCE_CYCLES), provided input held stable throughout. irq rises combinationally after that edge if mask bit set.
- Readdata of addr 0/2/3 reflects register state after the most recent edge; no read side effects.
- Simultaneous W1C and new qualifying edge on same bit: set wins, bit stays 1. W1C on other bits unaffected.
- Mask write takes effect on irq the cycle after the write edge; clearing mask does not clear capture.
- Pulse shorter than DEBOUNCE_CYCLES cycles at s2: no stable change, no capture.
- reset asserted mid-count: counters and captures cleared on that edge; after release, an input already at non-idle level is debounced from zero and produces a capture normally.
- DEBOUNCE_CYCLES = 1: stable follows s2 with one-cycle delay.

## Structure

- Package dnn_accel_system_keys_pkg: register address constants (ADDR_DATA=0, ADDR_MASK=2, ADDR_EDGE=3), EDGE_MODE encodings (EDGE_RISE, EDGE_FALL, EDGE_ANY).
- Sub-module dnn_accel_system_debounce: one bit, synchroniser + counter + stable register, outputs stable and a one-cycle rise/fall strobe; top instantiates WIDTH copies via generate and holds register file, capture logic, irq.

## Test plan

- Reset: assert reset 2 cycles -> readdata at addr 0 = 0xF, addr 2 = 0, addr 3 = 0, irq = 0.
- Falling edge, default params: drive in_port[1] 1→0 held 30 cycles, mask=0x2 -> capture=0x2 exactly 18 edges after change, irq=1; addr 0 reads 0xD.
- Glitch reject: 10-cycle low pulse on in_port[0] -> capture stays 0, data stays 0xF, irq=0.
- W1C: capture=0x3, write 0x1 to addr 3 -> capture=0x2; write 0x0 -> unchanged; write 0x2 -> 0, irq drops.
- Set beats clear: W1C of bit 2 on the same edge bit 2's stable falls -> capture bit 2 = 1.
- Reset mid-count: reset during count at cnt=8 on bit 3 held low -> after release capture=0, then capture bit 3 set 18 cycles later.

Source files
------------

// File: rtl/dnn_accel_system_keys_pkg.sv
// Shared register map and edge-mode encodings for the push-button/switch
// input port.
package dnn_accel_system_keys_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA = 2'd0,
    ADDR_RSVD = 2'd1,
    ADDR_MASK = 2'd2,
    ADDR_EDGE = 2'd3
  } reg_addr_e;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // One spare bit so a count of DEBOUNCE_CYCLES-1 always fits.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/dnn_accel_system_keys_if.sv
// Avalon-MM slave bus bundle used by the input port.
interface dnn_accel_system_keys_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/dnn_accel_system_debounce.sv
// One input bit: two-flop synchroniser, consecutive-cycle debounce counter and
// stable register, with single-cycle rise/fall strobes on each stable change.
module dnn_accel_system_debounce
  import dnn_accel_system_keys_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic IDLE_BIT        = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             update;

  // Any cycle where s2 agrees with the stable value restarts the count.
  always_comb begin
    s1_d     = din;
    s2_d     = s1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    update   = 1'b0;
    if (s2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        update   = 1'b1;
        stable_d = s2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= IDLE_BIT;
      s2_q     <= IDLE_BIT;
      stable_q <= IDLE_BIT;
      cnt_q    <= '0;
    end else begin
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;
  assign rise   = update & s2_q;
  assign fall   = update & ~s2_q;

endmodule

// File: rtl/dnn_accel_system_keys.sv
// Avalon-MM input port: debounced data register, sticky edge capture with
// write-1-to-clear, and a maskable level interrupt.
module dnn_accel_system_keys
  import dnn_accel_system_keys_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 16,
  parameter int               EDGE_MODE       = EDGE_FALL,
  parameter logic [WIDTH-1:0] IDLE_LEVEL      = '1
) (
  input  logic                    clk,
  input  logic                    reset,
  dnn_accel_system_keys_if.slave  avs,
  input  logic [WIDTH-1:0]        in_port,
  output logic                    irq
);

  logic [WIDTH-1:0] stable, rise, fall;
  logic [WIDTH-1:0] edge_set, clr;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] capture_q, capture_d;
  logic [WIDTH-1:0] wr_data;
  logic             wr_en;
  logic             unused_wdata;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    dnn_accel_system_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .IDLE_BIT       (IDLE_LEVEL[g])
    ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .din   (in_port[g]),
      .stable(stable[g]),
      .rise  (rise[g]),
      .fall  (fall[g])
    );
  end

  assign wr_en        = avs.chipselect & ~avs.write_n;
  assign wr_data      = avs.writedata[WIDTH-1:0];
  assign unused_wdata = ^avs.writedata;

  always_comb begin
    case (EDGE_MODE)
      EDGE_RISE: edge_set = rise;
      EDGE_FALL: edge_set = fall;
      default:   edge_set = rise | fall;
    endcase
  end

  // A new edge on the same cycle as its clear leaves the bit set.
  always_comb begin
    mask_d = mask_q;
    clr    = '0;
    if (wr_en && avs.address == ADDR_MASK) mask_d = wr_data;
    if (wr_en && avs.address == ADDR_EDGE) clr    = wr_data;
    capture_d = (capture_q & ~clr) | edge_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q    <= '0;
      capture_q <= '0;
    end else begin
      mask_q    <= mask_d;
      capture_q <= capture_d;
    end
  end

  always_comb begin
    avs.readdata = '0;
    case (avs.address)
      ADDR_DATA: avs.readdata = 32'(stable);
      ADDR_MASK: avs.readdata = 32'(mask_q);
      ADDR_EDGE: avs.readdata = 32'(capture_q);
      default:   avs.readdata = '0;
    endcase
  end

  assign irq = |(capture_q & mask_q);

endmodule

// File: tb/tb_dnn_accel_system_keys.sv
// Bench for dnn_accel_system_keys: directed scenarios plus randomized traffic
// checked against a run-length debounce reference model.
module tb_dnn_accel_system_keys;

  localparam int W  = 4;
  localparam int DB = 16;
  localparam int EM = 1;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] in_port;
  logic         irq;
  int           errors = 0;
  int           checks = 0;

  dnn_accel_system_keys_if bus ();

  dnn_accel_system_keys #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(DB),
    .EDGE_MODE      (EM),
    .IDLE_LEVEL     (4'hF)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .avs    (bus),
    .in_port(in_port),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  // Reference: a bit's stable value flips once the synchronised input has
  // disagreed with it on each of the last DB clock edges.
  logic [W-1:0] m_s1, m_s2, m_stable, m_mask, m_cap;
  logic [W-1:0] hist [DB];
  logic [W-1:0] m_nxt, m_set, m_clr;
  logic         m_all_diff;

  always @(posedge clk) begin
    if (reset) begin
      m_s1 = '1; m_s2 = '1; m_stable = '1; m_mask = '0; m_cap = '0;
      for (int i = 0; i < DB; i++) hist[i] = '1;
    end else begin
      for (int i = DB - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = m_s2;
      m_nxt = m_stable;
      for (int b = 0; b < W; b++) begin
        m_all_diff = 1'b1;
        for (int i = 0; i < DB; i++) if (hist[i][b] == m_stable[b]) m_all_diff = 1'b0;
        if (m_all_diff) m_nxt[b] = m_s2[b];
      end
      if (EM == 0)      m_set = m_nxt & ~m_stable;
      else if (EM == 1) m_set = ~m_nxt & m_stable;
      else              m_set = m_nxt ^ m_stable;
      m_clr = '0;
      if (bus.chipselect && !bus.write_n && bus.address == 2'd3) m_clr = bus.writedata[W-1:0];
      if (bus.chipselect && !bus.write_n && bus.address == 2'd2) m_mask = bus.writedata[W-1:0];
      m_cap    = (m_cap & ~m_clr) | m_set;
      m_stable = m_nxt;
      m_s2     = m_s1;
      m_s1     = in_port;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_stable);
      2'd2:    return 32'(m_mask);
      2'd3:    return 32'(m_cap);
      default: return 32'd0;
    endcase
  endfunction

  task automatic idle_bus();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.address    = 2'd0;
    bus.writedata  = 32'd0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    #1;
    d = bus.readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    @(negedge clk);
    idle_bus();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    in_port = 4'hF;
    idle_bus();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    rd(2'd0, d); checks++;
    if (d !== 32'hF) begin errors++; $display("[TB] FAIL reset_data got=%h exp=%h", d, 32'hF); end
    rd(2'd2, d); checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_mask got=%h exp=0", d); end
    rd(2'd3, d); checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL reset_capture got=%h exp=0", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq got=%b exp=0", irq); end
  endtask

  task automatic test_falling();
    logic [31:0] d;
    wr(2'd2, 32'h2);
    in_port = 4'b1101;
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      rd(2'd3, d); checks++;
      if (d !== ((n == 18) ? 32'h2 : 32'h0)) begin
        errors++; $display("[TB] FAIL fall_latency edge=%0d got=%h exp=%h", n, d, (n == 18) ? 32'h2 : 32'h0);
      end
    end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("[TB] FAIL fall_irq got=%b exp=1", irq); end
    rd(2'd0, d); checks++;
    if (d !== 32'hD) begin errors++; $display("[TB] FAIL fall_data got=%h exp=%h", d, 32'hD); end
    repeat (12) @(negedge clk);
    in_port = 4'hF;
    repeat (20) @(negedge clk);
    rd(2'd3, d); checks++;
    if (d !== 32'h2) begin errors++; $display("[TB] FAIL rise_ignored got=%h exp=%h", d, 32'h2); end
    wr(2'd3, 32'h2);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL fall_clear_irq got=%b exp=0", irq); end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    in_port = 4'hE;
    repeat (10) @(negedge clk);
    in_port = 4'hF;
    repeat (30) @(negedge clk);
    rd(2'd3, d); checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL glitch_capture got=%h exp=0", d); end
    rd(2'd0, d); checks++;
    if (d !== 32'hF) begin errors++; $display("[TB] FAIL glitch_data got=%h exp=%h", d, 32'hF); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL glitch_irq got=%b exp=0", irq); end
  endtask

  task automatic test_w1c();
    logic [31:0] d;
    in_port = 4'hC;
    repeat (20) @(negedge clk);
    in_port = 4'hF;
    repeat (20) @(negedge clk);
    rd(2'd3, d); checks++;
    if (d !== 32'h3) begin errors++; $display("[TB] FAIL w1c_setup got=%h exp=%h", d, 32'h3); end
    wr(2'd3, 32'h1);
    rd(2'd3, d); checks++;
    if (d !== 32'h2) begin errors++; $display("[TB] FAIL w1c_bit0 got=%h exp=%h", d, 32'h2); end
    wr(2'd3, 32'h0);
    rd(2'd3, d); checks++;
    if (d !== 32'h2) begin errors++; $display("[TB] FAIL w1c_zero got=%h exp=%h", d, 32'h2); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("[TB] FAIL w1c_irq_hi got=%b exp=1", irq); end
    wr(2'd3, 32'h2);
    rd(2'd3, d); checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL w1c_bit1 got=%h exp=0", d); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL w1c_irq_lo got=%b exp=0", irq); end
  endtask

  task automatic test_set_beats_clear();
    logic [31:0] d;
    in_port = 4'hB;
    repeat (17) @(negedge clk);
    wr(2'd3, 32'h4);
    rd(2'd3, d); checks++;
    if (d !== 32'h4) begin errors++; $display("[TB] FAIL set_wins got=%h exp=%h", d, 32'h4); end
    in_port = 4'hF;
    repeat (20) @(negedge clk);
    wr(2'd3, 32'h4);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    in_port = 4'h7;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rd(2'd3, d); checks++;
    if (d !== 32'h0) begin errors++; $display("[TB] FAIL midreset_capture got=%h exp=0", d); end
    rd(2'd0, d); checks++;
    if (d !== 32'hF) begin errors++; $display("[TB] FAIL midreset_data got=%h exp=%h", d, 32'hF); end
    for (int n = 1; n <= 18; n++) begin
      @(negedge clk);
      rd(2'd3, d);
      if (n >= 17) begin
        checks++;
        if (d !== ((n == 18) ? 32'h8 : 32'h0)) begin
          errors++; $display("[TB] FAIL midreset_latency edge=%0d got=%h exp=%h", n, d, (n == 18) ? 32'h8 : 32'h0);
        end
      end
    end
    in_port = 4'hF;
    repeat (20) @(negedge clk);
    wr(2'd3, 32'h8);
  endtask

  task automatic test_random();
    logic [31:0] d;
    int hold = 0;
    int op;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if (hold == 0) begin
        in_port = W'($urandom);
        hold = $urandom_range(1, 24);
      end else begin
        hold--;
      end
      op = $urandom_range(0, 9);
      bus.address   = 2'($urandom);
      bus.writedata = $urandom;
      bus.chipselect = (op != 9);
      bus.write_n    = !(op < 2 || op == 9);
      #1;
      d = bus.readdata;
      checks++;
      if (d !== exp_rd(bus.address)) begin
        errors++; $display("[TB] FAIL rand_read cyc=%0d addr=%0d got=%h exp=%h", cyc, bus.address, d, exp_rd(bus.address));
      end
      checks++;
      if (irq !== |(m_cap & m_mask)) begin
        errors++; $display("[TB] FAIL rand_irq cyc=%0d got=%b exp=%b", cyc, irq, |(m_cap & m_mask));
      end
    end
    @(negedge clk);
    idle_bus();
  endtask

  initial begin
    reset = 1'b1;
    in_port = 4'hF;
    idle_bus();
    test_reset();
    test_falling();
    test_glitch();
    test_w1c();
    test_set_beats_clear();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
